// File: rtl/sqr_pkg.sv
// rtl/sqr_pkg.sv - shared constants and state type for the sum-of-squares datapath
//
// Purpose: single source for the default operand/result widths, the FSM state
//          enumeration and the bit-counter width used by sqr_sum and by the
//          square-root stage that consumes its OUT_W-wide result.
// Ports:   none (package).
package sqr_pkg;

   localparam int SQR_IN_W  = 16;
   localparam int SQR_OUT_W = 32;

   // Counter width; never narrower than one bit so a degenerate IN_W=1 still works.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int SQR_CNT_W = cnt_width(SQR_IN_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQX  = 2'd1,
      SQY  = 2'd2,
      DONE = 2'd3
   } sqr_state_t;

endpackage

// File: rtl/sqr_step.sv
// rtl/sqr_step.sv - one combinational shift-add multiplication step
//
// Purpose: adds operand << shift into the accumulator when the current
//          multiplier bit is set; otherwise passes the accumulator through.
// Ports:   acc      - current accumulator (OUT_W)
//          operand  - unsigned multiplicand (IN_W)
//          mbit     - multiplier bit selected for this step
//          shift    - bit position of mbit (CNT_W)
//          acc_next - accumulator after this step (OUT_W)
module sqr_step
   import sqr_pkg::*;
#(
   parameter int IN_W  = SQR_IN_W,
   parameter int OUT_W = SQR_OUT_W,
   parameter int CNT_W = SQR_CNT_W
) (
   input  logic [OUT_W-1:0] acc,
   input  logic [IN_W-1:0]  operand,
   input  logic             mbit,
   input  logic [CNT_W-1:0] shift,
   output logic [OUT_W-1:0] acc_next
);

   logic [OUT_W-1:0] widened;

   // Zero-extend before shifting so high partial-product bits are not lost.
   assign widened  = {{(OUT_W-IN_W){1'b0}}, operand};
   assign acc_next = mbit ? (acc + (widened << shift)) : acc;

endmodule

// File: rtl/sqr_sum.sv
// rtl/sqr_sum.sv - sequential gx*gx + gy*gy for the gradient magnitude path
//
// Purpose: captures |gx| and |gy|, squares each with IN_W shift-add steps
//          (one bit per clock, LSB first) into a shared accumulator, and
//          presents the sum with a valid/ready handshake. Latency is a fixed
//          2*IN_W edges from the accepting edge to out_valid.
// Ports:   clk       - clock, rising edge
//          reset     - synchronous active-high reset
//          gx, gy    - signed two's-complement gradients (IN_W)
//          in_valid  - gx/gy valid
//          in_ready  - high only in IDLE
//          sum       - result (OUT_W), held until the next result or reset
//          out_valid - sum valid, high only in DONE
//          out_ready - downstream accepts sum
module sqr_sum
   import sqr_pkg::*;
#(
   parameter int IN_W  = SQR_IN_W,
   parameter int OUT_W = SQR_OUT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  gx,
   input  logic [IN_W-1:0]  gy,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] sum,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int               CNT_W    = cnt_width(IN_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

   sqr_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [IN_W-1:0]  opx;
   logic [IN_W-1:0]  opy;
   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] acc_next;
   logic [IN_W-1:0]  op_cur;
   logic             mbit;
   logic [IN_W-1:0]  gx_abs;
   logic [IN_W-1:0]  gy_abs;

   // Negating the most negative value wraps back to 2^(IN_W-1), which is
   // exactly its magnitude when read as unsigned.
   assign gx_abs = gx[IN_W-1] ? -gx : gx;
   assign gy_abs = gy[IN_W-1] ? -gy : gy;

   // The same operand is both multiplicand and multiplier for a square.
   assign op_cur = (state == SQY) ? opy : opx;
   assign mbit   = op_cur[cnt];

   sqr_step #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .CNT_W (CNT_W)
   ) u_step (
      .acc      (acc),
      .operand  (op_cur),
      .mbit     (mbit),
      .shift    (cnt),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         opx       <= '0;
         opy       <= '0;
         acc       <= '0;
         sum       <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opx      <= gx_abs;
                  opy      <= gy_abs;
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= SQX;
               end
            end
            SQX: begin
               acc <= acc_next;
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= SQY;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SQY: begin
               acc <= acc_next;
               if (cnt == CNT_LAST) begin
                  cnt       <= '0;
                  sum       <= acc_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sqr_sum.sv
// tb/tb_sqr_sum.sv - scoreboard bench for sqr_sum
module tb_sqr_sum;

   logic        clk;
   logic        reset;
   logic [15:0] gx;
   logic [15:0] gy;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] sum;
   logic        out_valid;
   logic        out_ready;

   typedef struct {
      logic [31:0] s;
      int          acc_edge;
   } exp_t;

   exp_t exp_q[$];
   int   acc_edges[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   prev_valid = 1'b0;
   bit   post_chk = 1'b0;
   bit   rand_bp = 1'b0;
   logic [31:0] last_sum;

   sqr_sum dut (
      .clk       (clk),
      .reset     (reset),
      .gx        (gx),
      .gy        (gy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain signed arithmetic, reduced modulo 2^32.
   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 32'(sa * sa + sb * sb);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: records accepts into the scoreboard and checks every output.
   always @(negedge clk) begin
      if (reset) begin
         post_chk = 1'b0;
      end else begin
         if (post_chk) begin
            chk("post_out_valid", 64'(out_valid), 64'(0));
            chk("post_in_ready", 64'(in_ready), 64'(1));
            chk("post_sum_kept", 64'(sum), 64'(last_sum));
            post_chk = 1'b0;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back('{s: model(gx, gy), acc_edge: cyc + 1});
            acc_edges.push_back(cyc + 1);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
               if (!prev_valid)
                  chk("latency", 64'(cyc - exp_q[0].acc_edge), 64'(32));
               chk("sum", 64'(sum), 64'(exp_q[0].s));
               if (out_ready) begin
                  last_sum = sum;
                  post_chk = 1'b1;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
      prev_valid = out_valid;
   end

   always @(posedge clk) begin
      if (rand_bp) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b);
      int n;
      @(posedge clk);
      #1;
      gx = a;
      gy = b;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      gx = 16'($urandom);
      gy = 16'($urandom);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'(0));
      @(negedge clk);
   endtask

   initial begin
      int base;
      int n;
      reset = 1'b1;
      in_valid = 1'b0;
      gx = '0;
      gy = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));

      // Basic values and the most-negative boundary.
      send(16'd3, 16'd4);
      wait_drain();
      send(16'h8000, 16'h8000);
      wait_drain();
      send(16'd0, 16'd0);
      wait_drain();

      // Backpressure: result must hold for 10 cycles.
      out_ready = 1'b0;
      send(16'hfff9, 16'd100);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", 64'(out_valid), 64'(1));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(out_valid), 64'(1));
         chk("bp_hold_sum", 64'(sum), 64'(10049));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain();

      // Reset on the 10th SQX edge aborts the operation.
      send(16'd300, 16'hff38);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("abort_in_ready", 64'(in_ready), 64'(1));
      chk("abort_out_valid", 64'(out_valid), 64'(0));
      chk("abort_sum", 64'(sum), 64'(0));
      send(16'd5, 16'd12);
      wait_drain();

      // Continuous in_valid with changing data across 3 operations.
      base = acc_edges.size();
      @(posedge clk);
      #1;
      gx = 16'($urandom);
      gy = 16'($urandom);
      in_valid = 1'b1;
      n = 0;
      while (n < 300) begin
         @(posedge clk);
         #1;
         if (acc_edges.size() >= base + 3) break;
         gx = 16'($urandom);
         gy = 16'($urandom);
         n++;
      end
      in_valid = 1'b0;
      chk("cont_accepts", 64'(acc_edges.size() - base), 64'(3));
      if (acc_edges.size() >= base + 3) begin
         chk("cont_spacing1", 64'(acc_edges[base+1] - acc_edges[base]), 64'(34));
         chk("cont_spacing2", 64'(acc_edges[base+2] - acc_edges[base+1]), 64'(34));
      end
      wait_drain();

      // Random operands with random backpressure, including extreme values.
      rand_bp = 1'b1;
      for (int i = 0; i < 15; i++) begin
         case (i % 5)
            0: send(16'h8000, 16'($urandom));
            1: send(16'h7fff, 16'h8000);
            default: send(16'($urandom), 16'($urandom));
         endcase
      end
      rand_bp = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
      $fatal(1);
   end

endmodule
